// File: rtl/mem_responder.sv
// Single-ported word RAM shared by the instruction-fetch and data ports of the
// 5-stage datapath, with a request/ready handshake and one-cycle read latency.
module mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_ready,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_ready,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACK = 2'd1,
        D_ACK = 2'd2
    } state_t;

    state_t             state;
    logic               last_data;
    logic               err_q;
    logic [31:0]        ram [0:DEPTH-1];

    logic [ADDR_W-1:0]  inst_idx;
    logic [ADDR_W-1:0]  data_idx;
    logic               data_req;
    logic               misaligned;
    logic               grant_data;
    logic               grant_inst;
    logic               do_write;
    logic               do_read;
    logic               unused_addr_bits;

    // Word index only; upper address bits alias, so addresses wrap.
    assign inst_idx = inst_addr[ADDR_W+1:2];
    assign data_idx = mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                mem_addr[31:ADDR_W+2]};

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        data_req   = mem_ren | mem_wen;
        misaligned = (mem_addr[1:0] != 2'b00);
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (state == IDLE) begin
            // Contended: data wins unless it won last time.
            grant_data = data_req && !(inst_ren && last_data);
            grant_inst = inst_ren && !grant_data;
        end
        do_write = grant_data && mem_wen && !misaligned;
        do_read  = grant_data && !mem_wen && !misaligned;
    end

    // NOTE: the RAM array has no reset; clearing it would turn the storage
    // into flops and reset must not destroy a completed write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            ram[data_idx] <= mem_dout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_data <= 1'b0;
            err_q     <= 1'b0;
            inst_data <= '0;
            mem_din   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        last_data <= 1'b1;
                        err_q     <= misaligned;
                        if (do_read) begin
                            mem_din <= ram[data_idx];
                        end
                        state <= D_ACK;
                    end else if (grant_inst) begin
                        last_data <= 1'b0;
                        inst_data <= ram[inst_idx];
                        state     <= I_ACK;
                    end
                end
                I_ACK: begin
                    state <= IDLE;
                end
                D_ACK: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready outputs decode registered state only, never the request inputs.
    assign inst_ready = (state == I_ACK);
    assign mem_ready  = (state == D_ACK);
    assign addr_err   = (state == D_ACK) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder plus hand-written sequences
// for throughput, arbitration and reset-during-acknowledge.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_ren = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic [31:0] mem_din;
    logic        mem_ready;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    mem_responder #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_ren   (inst_ren),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_ready  (mem_ready),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        iren;
        logic [31:0] iaddr;
        logic        mren;
        logic        mwen;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic        exp_iready;
        logic        exp_mready;
        logic        exp_err;
        logic [31:0] exp_idata;
        logic [31:0] exp_mdin;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, ".inst_ready"}, {31'd0, inst_ready}, 32'd0);
        check({name, ".mem_ready"},  {31'd0, mem_ready},  32'd0);
        check({name, ".addr_err"},   {31'd0, addr_err},   32'd0);
    endtask

    function automatic vec_t mk(input string name, input logic iren, input logic [31:0] iaddr,
                                input logic mren, input logic mwen, input logic [31:0] maddr,
                                input logic [31:0] wdata, input logic eir, input logic emr,
                                input logic eerr, input logic [31:0] eid, input logic [31:0] emd);
        vec_t v;
        v.name = name; v.iren = iren; v.iaddr = iaddr; v.mren = mren; v.mwen = mwen;
        v.maddr = maddr; v.wdata = wdata; v.exp_iready = eir; v.exp_mready = emr;
        v.exp_err = eerr; v.exp_idata = eid; v.exp_mdin = emd;
        return v;
    endfunction

    task automatic drop_requests();
        inst_ren = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk("wr_10",       0, 32'h0, 0, 1, 32'h10,   32'hDEADBEEF, 0, 1, 0, 32'h0,        32'h0);
        vecs[1]  = mk("rd_10_raw",   0, 32'h0, 1, 0, 32'h10,   32'h0,        0, 1, 0, 32'h0,        32'hDEADBEEF);
        vecs[2]  = mk("if_10",       1, 32'h10, 0, 0, 32'h0,   32'h0,        1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = mk("wr_13_mis",   0, 32'h0, 0, 1, 32'h13,   32'h12345678, 0, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[4]  = mk("rd_10_kept",  0, 32'h0, 1, 0, 32'h10,   32'h0,        0, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[5]  = mk("wr_00",       0, 32'h0, 0, 1, 32'h0,    32'hA5A5A5A5, 0, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[6]  = mk("rd_1000_wrap",0, 32'h0, 1, 0, 32'h1000, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'hA5A5A5A5);
        vecs[7]  = mk("rd_02_mis",   0, 32'h0, 1, 0, 32'h2,    32'h0,        0, 1, 1, 32'hDEADBEEF, 32'hA5A5A5A5);
        vecs[8]  = mk("wr_rd_20",    0, 32'h0, 1, 1, 32'h20,   32'h0BADF00D, 0, 1, 0, 32'hDEADBEEF, 32'hA5A5A5A5);
        vecs[9]  = mk("rd_20",       0, 32'h0, 1, 0, 32'h20,   32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h0BADF00D);
        vecs[10] = mk("if_21_low",   1, 32'h21, 0, 0, 32'h0,   32'h0,        1, 0, 0, 32'h0BADF00D, 32'h0BADF00D);
        vecs[11] = mk("if_00",       1, 32'h0, 0, 0, 32'h0,    32'h0,        1, 0, 0, 32'hA5A5A5A5, 32'h0BADF00D);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset.inst_data", inst_data, 32'h0);
        check("reset.mem_din",   mem_din,   32'h0);
        rst = 1'b0;

        // Back-to-back single-port transactions: request, ack next cycle, idle after.
        for (int i = 0; i < 12; i++) begin
            inst_ren  = vecs[i].iren;
            inst_addr = vecs[i].iaddr;
            mem_ren   = vecs[i].mren;
            mem_wen   = vecs[i].mwen;
            mem_addr  = vecs[i].maddr;
            mem_dout  = vecs[i].wdata;
            @(posedge clk);
            #1;
            check({vecs[i].name, ".inst_ready"}, {31'd0, inst_ready}, {31'd0, vecs[i].exp_iready});
            check({vecs[i].name, ".mem_ready"},  {31'd0, mem_ready},  {31'd0, vecs[i].exp_mready});
            check({vecs[i].name, ".addr_err"},   {31'd0, addr_err},   {31'd0, vecs[i].exp_err});
            check({vecs[i].name, ".inst_data"},  inst_data, vecs[i].exp_idata);
            check({vecs[i].name, ".mem_din"},    mem_din,   vecs[i].exp_mdin);
            drop_requests();
            @(posedge clk);
            #1;
            check_idle({vecs[i].name, ".after"});
        end

        // Held instruction request: accepted every second cycle.
        inst_ren  = 1'b1;
        inst_addr = 32'h10;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("if_hold.c%0d.inst_ready", k + 1), {31'd0, inst_ready},
                  (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("if_hold.inst_data", inst_data, 32'hDEADBEEF);
        drop_requests();
        @(posedge clk);
        #1;
        check_idle("if_hold.after");

        // Contention from reset: data first, then alternating.
        rst       = 1'b1;
        inst_ren  = 1'b1;
        inst_addr = 32'h0;
        mem_ren   = 1'b1;
        mem_addr  = 32'h10;
        #1;
        check_idle("contend.in_reset");
        check("contend.in_reset.mem_din", mem_din, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("contend.e%0d.mem_ready", k),  {31'd0, mem_ready},
                  (k % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("contend.e%0d.inst_ready", k), {31'd0, inst_ready},
                  (k % 4 == 2) ? 32'd1 : 32'd0);
        end
        check("contend.mem_din",   mem_din,   32'hDEADBEEF);
        check("contend.inst_data", inst_data, 32'hA5A5A5A5);
        drop_requests();
        @(posedge clk);
        #1;
        check_idle("contend.after");

        // Reset asserted during I_ACK.
        inst_ren  = 1'b1;
        inst_addr = 32'h10;
        @(posedge clk);
        #1;
        check("rst_iack.pre.inst_ready", {31'd0, inst_ready}, 32'd1);
        check("rst_iack.pre.inst_data",  inst_data, 32'hDEADBEEF);
        rst      = 1'b1;
        inst_ren = 1'b0;
        #1;
        check("rst_iack.inst_ready", {31'd0, inst_ready}, 32'd0);
        check("rst_iack.inst_data",  inst_data, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        inst_ren = 1'b1;
        @(posedge clk);
        #1;
        check("rst_iack.post.inst_ready", {31'd0, inst_ready}, 32'd1);
        check("rst_iack.post.inst_data",  inst_data, 32'hDEADBEEF);
        drop_requests();
        @(posedge clk);
        #1;
        check_idle("rst_iack.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
